// File: rtl/pkt_pkg.sv
// Shared constants and state encoding for the receive-side padding stripper.
package pkt_pkg;

    localparam int DEFAULT_BLOCK_WORDS = 16;

    localparam logic [63:0] PAD_WORD  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ZERO_WORD = 64'h0000_0000_0000_0000;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_LEN_ALIGN = 3'd1;
    localparam logic [2:0] ERR_LEN_RANGE = 3'd2;
    localparam logic [2:0] ERR_BAD_PAD   = 3'd3;
    localparam logic [2:0] ERR_BAD_ZERO  = 3'd4;
    localparam logic [2:0] ERR_BLK_ALIGN = 3'd5;

    typedef enum logic [2:0] {
        ACCEPT,
        CHECK_LEN,
        EMIT,
        PADCHK,
        FLUSH,
        DONE
    } state_e;

endpackage

// File: rtl/pkt_holdbuf.sv
// Synchronous circular FIFO holding back words until it is known they are payload.
module pkt_holdbuf #(
    parameter int DEPTH = 18,
    parameter int W     = 64,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [CW-1:0] count,
    output logic [W-1:0]  head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= din;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pkt_unpad.sv
// Strips pad/zero/length words from a padded 64-bit stream and reports the
// recovered message length plus any padding or framing error.
module pkt_unpad
    import pkt_pkg::*;
#(
    parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS,
    parameter int HOLD        = BLOCK_WORDS + 2,
    parameter int CNT_W       = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_pkt,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [63:0] out_pkt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        done,
    output logic [63:0] msg_len,
    output logic        err,
    output logic [2:0]  err_code
);

    localparam int CW = $clog2(HOLD + 1);
    localparam int BW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
    localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD);

    state_e             state_q, state_d;
    logic [63:0]        msg_len_q, msg_len_d;
    logic [CNT_W-1:0]   emitted_q, emitted_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [BW-1:0]      blkpos_q, blkpos_d;
    logic [2:0]         err_code_q, err_code_d;
    logic               first_q, first_d;

    logic               push, pop, flush;
    logic [CW-1:0]      buf_count;
    logic [63:0]        buf_head;

    logic               n_too_big;
    logic [CNT_W:0]     rem_full;
    logic               rem_too_big;

    pkt_holdbuf #(
        .DEPTH (HOLD),
        .W     (64)
    ) u_holdbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (in_pkt),
        .count (buf_count),
        .head  (buf_head)
    );

    // rem = N - emitted, with the extra top bit flagging a negative result.
    assign n_too_big   = (msg_len_q[63:CNT_W+6] != '0);
    assign rem_full    = {1'b0, msg_len_q[CNT_W+5:6]} - {1'b0, emitted_q};
    assign rem_too_big = (rem_full[CNT_W-1:0] >= {{(CNT_W-CW){1'b0}}, buf_count});

    always_comb begin
        state_d    = state_q;
        msg_len_d  = msg_len_q;
        emitted_d  = emitted_q;
        rem_d      = rem_q;
        blkpos_d   = blkpos_q;
        err_code_d = err_code_q;
        first_d    = first_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        err_code   = ERR_NONE;

        case (state_q)
            ACCEPT: begin
                // A full buffer guarantees the head is followed by more words than any padding tail.
                out_valid = (buf_count == HOLD_CNT);
                pop       = out_valid && out_ready;
                in_ready  = (buf_count < HOLD_CNT) || pop;
                if (in_valid && in_ready) begin
                    blkpos_d = (blkpos_q == BW'(BLOCK_WORDS - 1)) ? '0 : blkpos_q + 1'b1;
                    if (in_last) begin
                        msg_len_d = in_pkt;
                        state_d   = CHECK_LEN;
                    end else begin
                        push = 1'b1;
                    end
                end
            end
            CHECK_LEN: begin
                if (msg_len_q[5:0] != 6'd0) begin
                    err_code_d = ERR_LEN_ALIGN;
                    state_d    = FLUSH;
                end else if (blkpos_q != '0) begin
                    err_code_d = ERR_BLK_ALIGN;
                    state_d    = FLUSH;
                end else if (n_too_big || rem_full[CNT_W] || rem_too_big) begin
                    err_code_d = ERR_LEN_RANGE;
                    state_d    = FLUSH;
                end else if (rem_full[CNT_W-1:0] != '0) begin
                    rem_d   = rem_full[CNT_W-1:0];
                    state_d = EMIT;
                end else begin
                    first_d = 1'b1;
                    state_d = PADCHK;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (rem_q == CNT_W'(1));
                pop       = out_ready;
                if (out_ready) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CNT_W'(1)) begin
                        first_d = 1'b1;
                        state_d = PADCHK;
                    end
                end
            end
            PADCHK: begin
                if (buf_count == '0) begin
                    state_d = DONE;
                end else begin
                    pop     = 1'b1;
                    first_d = 1'b0;
                    if (first_q && (buf_head != PAD_WORD)) begin
                        err_code_d = ERR_BAD_PAD;
                        state_d    = FLUSH;
                    end else if (!first_q && (buf_head != ZERO_WORD)) begin
                        err_code_d = ERR_BAD_ZERO;
                        state_d    = FLUSH;
                    end else if (buf_count == CW'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = (err_code_q != ERR_NONE);
                err_code   = err_code_q;
                emitted_d  = '0;
                blkpos_d   = '0;
                err_code_d = ERR_NONE;
                state_d    = ACCEPT;
            end
            default: state_d = ACCEPT;
        endcase

        if (out_valid && out_ready) emitted_d = emitted_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCEPT;
            msg_len_q  <= '0;
            emitted_q  <= '0;
            rem_q      <= '0;
            blkpos_q   <= '0;
            err_code_q <= ERR_NONE;
            first_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            msg_len_q  <= msg_len_d;
            emitted_q  <= emitted_d;
            rem_q      <= rem_d;
            blkpos_q   <= blkpos_d;
            err_code_q <= err_code_d;
            first_q    <= first_d;
        end
    end

    // The head is gated so an empty or stale buffer never shows on the output.
    assign out_pkt = out_valid ? buf_head : '0;
    assign msg_len = msg_len_q;

endmodule

// File: tb/tb_pkt_unpad.sv
// Directed bench for pkt_unpad: clean, empty, stalled, errored and reset-interrupted messages.
module tb_pkt_unpad;
    import pkt_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_pkt;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_pkt;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        done;
    logic [63:0] msg_len;
    logic        err;
    logic [2:0]  err_code;

    int          vec_count   = 0;
    int          miscompares = 0;
    int          accepted_cnt;
    int          done_cnt    = 0;
    int          done_before;

    logic [63:0] stim_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] got_q[$];
    logic        last_q[$];
    logic [63:0] got_len;
    logic        got_err;
    logic [2:0]  got_code;

    always #5 clk = ~clk;

    pkt_unpad dut (
        .clk       (clk),
        .rst       (rst),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_pkt   (out_pkt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .done      (done),
        .msg_len   (msg_len),
        .err       (err),
        .err_code  (err_code)
    );

    // Record output handshakes and done pulses mid-cycle, well clear of the rising edge.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            if (out_valid && out_ready) begin
                got_q.push_back(out_pkt);
                last_q.push_back(out_last);
            end
            if (done) begin
                done_cnt++;
                got_len  = msg_len;
                got_err  = err;
                got_code = err_code;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vec_count++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Payload, then a pad word, zero words (one optionally corrupted) and the length word.
    task automatic build_msg(input int id, input int n_pay, input logic [63:0] pad,
                             input int n_zero, input int bad_idx, input logic [63:0] len);
        stim_q.delete();
        exp_q.delete();
        for (int i = 0; i < n_pay; i++) begin
            stim_q.push_back({8'hA5, 24'(id), 32'(i + 1)});
            exp_q.push_back({8'hA5, 24'(id), 32'(i + 1)});
        end
        stim_q.push_back(pad);
        for (int i = 0; i < n_zero; i++)
            stim_q.push_back((i == bad_idx) ? 64'h0000_0100_0000_0000 : 64'h0);
        stim_q.push_back(len);
    endtask

    // Must be entered on a falling edge; drives the first n_words of stim_q.
    task automatic applyStimulus(input int n_words);
        logic rdy;
        logic taken;
        accepted_cnt = 0;
        for (int i = 0; i < n_words; i++) begin
            in_pkt   = stim_q[i];
            in_last  = (i == stim_q.size() - 1);
            in_valid = 1'b1;
            taken    = 1'b0;
            for (int t = 0; t < 400 && !taken; t++) begin
                #2;
                rdy = in_ready;
                @(negedge clk);
                if (rdy) begin
                    accepted_cnt++;
                    taken = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_pkt   = '0;
    endtask

    task automatic start_msg();
        done_before = done_cnt;
        got_q.delete();
        last_q.delete();
    endtask

    task automatic check_result(input string tag, input logic [2:0] exp_code);
        for (int t = 0; t < 500 && done_cnt == done_before; t++) @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_accepted"}, 64'(accepted_cnt), 64'(stim_q.size()));
        checkOutput({tag, "_done_pulses"}, 64'(done_cnt - done_before), 64'(1));
        checkOutput({tag, "_num_out"}, 64'(got_q.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < got_q.size()) begin
                checkOutput($sformatf("%s_word%0d", tag, i), got_q[i], exp_q[i]);
                checkOutput($sformatf("%s_last%0d", tag, i), 64'(last_q[i]), 64'(i == exp_q.size() - 1));
            end
        end
        checkOutput({tag, "_msg_len"}, got_len, stim_q[stim_q.size() - 1]);
        checkOutput({tag, "_err"}, 64'(got_err), 64'(exp_code != ERR_NONE));
        checkOutput({tag, "_err_code"}, 64'(got_code), 64'(exp_code));
    endtask

    task automatic run_msg(input string tag, input logic [2:0] exp_code);
        start_msg();
        applyStimulus(stim_q.size());
        check_result(tag, exp_code);
    endtask

    task automatic check_idle(input string tag);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'(1));
        checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        checkOutput({tag, "_out_last"}, 64'(out_last), 64'(0));
        checkOutput({tag, "_out_pkt"}, out_pkt, 64'(0));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
        checkOutput({tag, "_msg_len"}, msg_len, 64'(0));
        checkOutput({tag, "_err"}, 64'(err), 64'(0));
        checkOutput({tag, "_err_code"}, 64'(err_code), 64'(0));
    endtask

    initial begin
        rst       = 1'b1;
        in_pkt    = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #3;
        check_idle("reset");
        @(negedge clk);

        build_msg(1, 3, PAD_WORD, 11, -1, 64'd192);
        run_msg("three_words", ERR_NONE);

        // Downstream stalls long enough for the hold buffer to fill completely.
        build_msg(2, 15, PAD_WORD, 15, -1, 64'd960);
        start_msg();
        out_ready = 1'b0;
        fork
            applyStimulus(stim_q.size());
            begin
                repeat (20) @(negedge clk);
                checkOutput("stall_accepted", 64'(accepted_cnt), 64'(18));
                checkOutput("stall_out_valid", 64'(out_valid), 64'(1));
                checkOutput("stall_no_output", 64'(got_q.size()), 64'(0));
                out_ready = 1'b1;
            end
        join
        check_result("stalled", ERR_NONE);

        build_msg(3, 0, PAD_WORD, 14, -1, 64'd0);
        run_msg("empty", ERR_NONE);

        build_msg(4, 2, PAD_WORD, 12, -1, 64'd130);
        exp_q.delete();
        run_msg("len_align", ERR_LEN_ALIGN);

        build_msg(5, 3, PAD_WORD, 11, -1, 64'd192);
        run_msg("recover", ERR_NONE);

        build_msg(6, 2, 64'h1, 12, -1, 64'd128);
        run_msg("bad_pad", ERR_BAD_PAD);

        build_msg(7, 2, PAD_WORD, 12, 5, 64'd128);
        run_msg("bad_zero", ERR_BAD_ZERO);

        build_msg(8, 2, PAD_WORD, 11, -1, 64'd128);
        exp_q.delete();
        run_msg("blk_align", ERR_BLK_ALIGN);

        // Reset after ten words of a message: no done pulse, everything back to idle.
        build_msg(9, 3, PAD_WORD, 11, -1, 64'd192);
        start_msg();
        applyStimulus(10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check_idle("mid_reset");
        repeat (5) @(negedge clk);
        checkOutput("mid_reset_no_done", 64'(done_cnt - done_before), 64'(0));

        build_msg(10, 4, PAD_WORD, 10, -1, 64'd256);
        run_msg("after_reset", ERR_NONE);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule

// File: doc/pkt_unpad.md
Name: pkt_unpad

Overview:
- Receive-side counterpart of the transmit padding mux: consumes the padded 64-bit packet stream (payload words, one pad word 64'h8000000000000000, zero words, one final length word) and strips the padding.
- Emits only payload words, then reports the recovered message length in bits and any padding/framing error.
- Sits between the link/block source and the message consumer; one message is processed at a time.

Parameters:
- BLOCK_WORDS, 16, words per block. The length word is always at index BLOCK_WORDS-1 of the final block.
- HOLD, BLOCK_WORDS+2, depth of the hold-back buffer.
- CNT_W, 32, width of the payload word counters.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- in_pkt  in  64  input packet word
- in_valid  in  1  input word valid
- in_last  in  1  marks the length word (final word of padded stream)
- in_ready  out  1  input accepted when in_valid&in_ready
- out_pkt  out  64  payload word
- out_valid  out  1  payload word valid
- out_ready  in  1  downstream accept
- out_last  out  1  final payload word of message
- done  out  1  one-cycle pulse: message finished
- msg_len  out  64  captured length word, valid when done
- err  out  1  valid with done
- err_code  out  3  0 NONE, 1 LEN_ALIGN, 2 LEN_RANGE, 3 BAD_PAD, 4 BAD_ZERO, 5 BLK_ALIGN

Behaviour:
- Interface: single clock clk; reset rst is synchronous, active-high.
- Reset values: all outputs 0, buffer empty, counters 0, state ACCEPT.
- Reset mid-message: buffered words are discarded and no done pulse is generated.
- ACCEPT state:
  - in_ready = (cnt<HOLD) | pop_this_cycle.
  - Non-last words are pushed into the FIFO.
  - The head is released as payload (out_valid=1, out_last=0) only when cnt==HOLD. At that point it has at least 18 successors, and maximum trailing padding is 17 words (pad + BLOCK_WORDS-1 zeros + length).
  - Invariant: a released word is never the final payload word.
  - Counters: emitted increments per out handshake; blkpos = (words accepted incl. length) mod BLOCK_WORDS.
- Length word (in_valid&in_ready&in_last):
  - Not pushed; captured into msg_len.
  - in_ready=0 until back in ACCEPT. Next state CHECK_LEN.
- CHECK_LEN (1 cycle), with N = msg_len>>6 and rem = N-emitted. Checks in priority order:
  - msg_len[5:0]!=0 -> LEN_ALIGN.
  - blkpos after length !=0 -> BLK_ALIGN.
  - N>=2^CNT_W, rem<0, or rem>cnt-1 -> LEN_RANGE.
  - Any error -> FLUSH. Else rem>0 -> EMIT; rem==0 -> PADCHK.
- EMIT: pop rem words via out handshake; out_last=1 on the rem-th word; then go to PADCHK.
- PADCHK: one internal pop per cycle, no output.
  - First popped word != PAD_WORD -> BAD_PAD.
  - Any later nonzero word -> BAD_ZERO.
  - Error -> FLUSH. Buffer empty -> DONE.
- FLUSH: clear buffer in one cycle, hold err_code, go to DONE.
- DONE: done=1 for exactly one cycle with msg_len, err, err_code valid.
  - Then clear emitted, blkpos and err; go to ACCEPT.
  - err/err_code are 0 outside DONE.
- N==0 (stream = pad, 14 zeros, length 0): no out_valid, no out_last, done with err=0.
- out_pkt/out_last are held stable while out_valid&!out_ready.
- The in_ready combinational path from out_ready is permitted.

Decomposition:
- pkt_pkg holds: PAD_WORD, ZERO_WORD, BLOCK_WORDS default, err_code constants, and the state encoding ACCEPT, CHECK_LEN, EMIT, PADCHK, FLUSH, DONE.
- Sub-module pkt_holdbuf: synchronous FIFO, depth HOLD, 64-bit, with push/pop/flush/count/head; registered storage, combinational head.

Test Plan:
- 3 payload words A,B,C, pad, 11 zeros, length 64'd192 (16 words), out_ready=1 -> outputs A,B,C with out_last on C; done, msg_len=192, err=0.
- 15 payload words, pad, 15 zeros, length 960 (32 words), out_ready held low 20 cycles then high -> in_ready stalls at cnt=18; 15 words emitted in order, out_last on word 15; no loss or duplication; err=0.
- Empty message: pad, 14 zeros, length 0 -> no out_valid; done with err=0, msg_len=0.
- 2 payload, pad, 12 zeros, length 130 -> done, err=1, err_code=1 (LEN_ALIGN); buffer flushed; next valid message processed normally.
- 2 payload, 64'h1, 12 zeros, length 128 -> payload emitted, then err_code=3 (BAD_PAD). Variant with a nonzero zero-word -> err_code=4. Total 15 words -> err_code=5.
- rst asserted mid-stream after 10 words -> next cycle all outputs 0, in_ready=1; a following clean message completes correctly.
